// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte sources.
// Define UART_TX_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module uart_tx_sched #(
    parameter  int NUM_REQ      = 4,
    parameter  int FRAME_CYCLES = 11,
    parameter  int GAP_CYCLES   = 0,
    localparam int GW           = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    output logic [GW-1:0]        o_grant_id,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]   data_q, data_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] winner_s;
    logic [7:0]   win_data_s;
    logic         any_valid_s;
    logic [NUM_REQ-1:0] ready_s;
    logic         done_s;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    // Winner select: lowest valid index; descending scan lets the lowest overwrite last.
    always_comb begin
        winner_s    = '0;
        win_data_s  = 8'h00;
        any_valid_s = |i_req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            winner_s   = i_req_valid[i] ? GW'(i) : winner_s;
            win_data_s = i_req_valid[i] ? i_req_data[8*i +: 8] : win_data_s;
        end
    end
`else
    logic [GW-1:0] ptr_q, ptr_d;

    // Winner select: first valid at ptr+1, ptr+2, ... (wrapping); descending offset scan keeps the nearest.
    always_comb begin
        int idx;
        idx         = 0;
        winner_s    = '0;
        win_data_s  = 8'h00;
        any_valid_s = |i_req_valid;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx        = int'(ptr_q) + k;
            idx        = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            winner_s   = i_req_valid[idx] ? GW'(idx) : winner_s;
            win_data_s = i_req_valid[idx] ? i_req_data[8*idx +: 8] : win_data_s;
        end
    end

    // Pointer register: moves to the winner only on an accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= GW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d = (state_q == ST_IDLE && any_valid_s) ? winner_s : ptr_q;
`endif

    // Next-state, counter and accept logic; START already counts as the first frame clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        ready_s = '0;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    ready_s[winner_s] = 1'b1;
                    data_d            = win_data_s;
                    grant_d           = winner_s;
                    state_d           = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d   = CW'(FRAME_CYCLES - 2);
                state_d = ST_FRAME;
            end
            ST_FRAME: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = CW'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and held byte/grant registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign o_req_ready = ready_s;
    assign o_tx_data   = data_q;
    assign o_grant_id  = grant_q;
    assign o_tx_start  = (state_q == ST_START);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_s;

endmodule
